bpu: RTL

//  Branch prediction unit at the receiving end of jmp2bpu_itf (modport .bpu).

---
 rtl/rv32i_types.sv | 35 +++
 rtl/jmp2bpu_itf.sv | 12 +
 rtl/bpu_btb_ram.sv | 36 +++
 rtl/bpu.sv | 104 ++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types: jump-unit opcodes and the BTB entry layout.
package rv32i_types;

    typedef enum logic [3:0] {
        jmp_op_jal  = 4'd0,
        jmp_op_jalr = 4'd1,
        jmp_op_beq  = 4'd2,
        jmp_op_bne  = 4'd3,
        jmp_op_blt  = 4'd4,
        jmp_op_bge  = 4'd5,
        jmp_op_bltu = 4'd6,
        jmp_op_bgeu = 4'd7
    } jmp_op_t;

    localparam logic [1:0] BPU_CTR_WEAK_T   = 2'b10;
    localparam logic [1:0] BPU_CTR_STRONG_T = 2'b11;

    // Tag field is sized for the smallest legal index (30 bits); narrower
    // tags are zero-extended, so the constant upper bits fold away.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } bpu_entry_t;

    // Two-bit saturating counter step.
    function automatic logic [1:0] bpu_ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/jmp2bpu_itf.sv
// Commit-time training channel from the jump unit to the branch predictor.
interface jmp2bpu_itf;
    logic        execute;
    logic [3:0]  opc;
    logic        update;
    logic [31:0] execute_pc;
    logic [31:0] execute_target;
    logic        execute_taken;

    modport bpu (input execute, opc, update, execute_pc, execute_target, execute_taken);
    modport jmp (output execute, opc, update, execute_pc, execute_target, execute_taken);
endinterface

// File: rtl/bpu_btb_ram.sv
// BTB storage: flop array, async-read fetch and training ports, one sync write port.
module bpu_btb_ram
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] fetch_idx,
    output bpu_entry_t       fetch_entry,
    input  logic [IDX_W-1:0] train_idx,
    output bpu_entry_t       train_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  bpu_entry_t       wr_entry
);

    bpu_entry_t mem [DEPTH];

    // Both read ports see registered contents only; writes land next cycle.
    assign fetch_entry = mem[fetch_idx];
    assign train_entry = mem[train_idx];

    // Table write with asynchronous clear of every entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/bpu.sv
// Branch prediction unit: direct-mapped BTB with 2-bit counters, trained at commit.
module bpu
    import rv32i_types::*;
#(
    parameter int unsigned BTB_DEPTH = 64,
    parameter int unsigned IDX_W     = $clog2(BTB_DEPTH),
    parameter int unsigned TAG_W     = 30 - IDX_W,
    parameter int unsigned STAT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    jmp2bpu_itf.bpu           jmp2bpu_itf,
    input  logic [31:0]       fetch_pc,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic [STAT_W-1:0] stat_exec,
    output logic [STAT_W-1:0] stat_correct
);

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic [IDX_W-1:0] t_idx;
    logic [TAG_W-1:0] t_tag;
    bpu_entry_t       f_entry;
    bpu_entry_t       t_entry;
    bpu_entry_t       wr_entry;
    logic             wr_en;
    logic             f_hit;
    logic             t_hit;
    logic             t_pred;
    logic             unused_pc_bits;

    assign f_idx = fetch_pc[IDX_W+1:2];
    assign f_tag = fetch_pc[31:IDX_W+2];
    assign t_idx = jmp2bpu_itf.execute_pc[IDX_W+1:2];
    assign t_tag = jmp2bpu_itf.execute_pc[31:IDX_W+2];
    assign unused_pc_bits = ^jmp2bpu_itf.execute_pc[1:0];

    bpu_btb_ram #(
        .DEPTH (BTB_DEPTH),
        .IDX_W (IDX_W)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_idx   (f_idx),
        .fetch_entry (f_entry),
        .train_idx   (t_idx),
        .train_entry (t_entry),
        .wr_en       (wr_en),
        .wr_idx      (t_idx),
        .wr_entry    (wr_entry)
    );

    assign f_hit = f_entry.valid && (f_entry.tag == 30'(f_tag));
    assign t_hit = t_entry.valid && (t_entry.tag == 30'(t_tag));
    assign t_pred = t_hit && t_entry.ctr[1];

    assign pred_valid  = f_hit;
    assign pred_taken  = f_hit && f_entry.ctr[1];
    assign pred_target = f_hit ? f_entry.target : fetch_pc + 32'd4;

    // Training: allocate on update, otherwise adjust a resident entry; misses leave the table alone.
    always_comb begin
        wr_en    = 1'b0;
        wr_entry = t_entry;
        if (jmp2bpu_itf.execute) begin
            if (jmp2bpu_itf.update) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = 30'(t_tag);
                wr_entry.target = jmp2bpu_itf.execute_target;
                wr_entry.ctr    = (jmp2bpu_itf.opc == jmp_op_jal) ? BPU_CTR_STRONG_T : BPU_CTR_WEAK_T;
            end else if (t_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = bpu_ctr_step(t_entry.ctr, jmp2bpu_itf.execute_taken);
                if (jmp2bpu_itf.execute_taken) begin
                    wr_entry.target = jmp2bpu_itf.execute_target;
                end
            end
        end
    end

    // Saturating performance counters, scored against the pre-update prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_exec    <= '0;
            stat_correct <= '0;
        end else if (jmp2bpu_itf.execute) begin
            if (stat_exec != '1) begin
                stat_exec <= stat_exec + STAT_W'(1);
            end
            if ((t_pred == jmp2bpu_itf.execute_taken) && (stat_correct != '1)) begin
                stat_correct <= stat_correct + STAT_W'(1);
            end
        end
    end

    a_no_update_without_execute: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(jmp2bpu_itf.update && !jmp2bpu_itf.execute)
    );

endmodule
